// File: rtl/ordered_release_pkg.sv
// Shared types for the ordered release stage: lane entry, controller
// states and a modular serial-number compare.
package ordered_release_pkg;

    localparam int NUM_LANES_DEF = 8;
    localparam int DATA_W_DEF = 128;
    localparam int SN_W_DEF = 32;
    localparam int DEPTH_DEF = 4;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [SN_W_DEF-1:0]   sn;
        logic                  joined;
    } lane_entry_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        TERM,
        DONE
    } state_t;

    // d is a w-bit modular difference; true when it lies in the upper half
    function automatic logic half_ge(input logic [63:0] d, input int w);
        return ((d >> (w - 1)) & 64'd1) != 64'd0;
    endfunction

endpackage

// File: rtl/ordered_release_unit_if.sv
// Lane-side and stream-side bundle of the ordered release stage.
import ordered_release_pkg::*;

interface ordered_release_unit_if #(
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SN_W = SN_W_DEF
);
    logic [NUM_LANES-1:0]             in_valid;
    logic [NUM_LANES-1:0]             in_ready;
    logic [NUM_LANES-1:0][DATA_W-1:0] in_data;
    logic [NUM_LANES-1:0][SN_W-1:0]   in_serialnum;
    logic [NUM_LANES-1:0]             in_joined;
    logic [NUM_LANES-1:0]             in_last_processed;
    logic [DATA_W-1:0]                out_data;
    logic                             out_valid;
    logic                             out_ready;
    logic                             out_last;
    logic                             out_empty;
    logic [SN_W-1:0]                  next_sn;
    logic                             order_err;
    logic [31:0]                      joined_cnt;
    logic [31:0]                      dropped_cnt;

    modport master (
        output in_valid, in_data, in_serialnum, in_joined,
        output in_last_processed, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_empty,
        input  next_sn, order_err, joined_cnt, dropped_cnt
    );

    modport slave (
        input  in_valid, in_data, in_serialnum, in_joined,
        input  in_last_processed, out_ready,
        output in_ready, out_data, out_valid, out_last, out_empty,
        output next_sn, order_err, joined_cnt, dropped_cnt
    );
endinterface

// File: rtl/ordered_release_unit_lane_fifo.sv
// Per-lane synchronous FIFO; head is read straight from the storage
// registers so it is valid the cycle after the push.
import ordered_release_pkg::*;

module lane_fifo #(
    parameter int W = 8,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic         single
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign single = cnt == (AW+1)'(1);
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign head = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/ordered_release_unit.sv
// In-order release of per-lane join results onto one stream, with
// marker dropping, end-of-stream termination and order checking.
import ordered_release_pkg::*;

module ordered_release_unit #(
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SN_W = SN_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input logic clk,
    input logic resetn,
    ordered_release_unit_if.slave bus
);
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SN_W-1:0]   sn;
        logic              joined;
    } entry_t;

    localparam int EW = $bits(entry_t);

    state_t               state;
    state_t               state_nx;
    logic                 ready_en;
    logic [SN_W-1:0]      next_sn;
    logic [31:0]          joined_cnt;
    logic [31:0]          dropped_cnt;
    logic                 order_err;
    logic [DATA_W-1:0]    out_data;
    logic                 out_valid;
    logic                 out_last;
    logic                 out_empty;
    entry_t               wr [NUM_LANES];
    entry_t               head [NUM_LANES];
    logic [SN_W-1:0]      last_sn [NUM_LANES];
    logic [NUM_LANES-1:0] seen;
    logic [NUM_LANES-1:0] full;
    logic [NUM_LANES-1:0] empty;
    logic [NUM_LANES-1:0] single;
    logic [NUM_LANES-1:0] rdy;
    logic [NUM_LANES-1:0] push;
    logic [NUM_LANES-1:0] pop;
    logic [NUM_LANES-1:0] hit;
    logic [DATA_W-1:0]    sel_data;
    logic                 sel_joined;
    logic                 hit_any;
    logic                 all_last;
    logic                 all_empty;
    logic                 empty_after;
    logic                 drain_eff;
    logic                 out_fire;
    logic                 out_free;
    logic                 pop_ok;
    logic                 load_rec;
    logic                 load_term;
    logic                 final_pop;
    logic                 term_go;
    logic                 ord_bad;

    assign all_last = &bus.in_last_processed;
    assign rdy = (ready_en && state != DONE) ? ~full : '0;
    assign push = bus.in_valid & rdy;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign wr[g] = '{
            data: bus.in_data[g],
            sn: bus.in_serialnum[g],
            joined: bus.in_joined[g]
        };
        lane_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
            .clk(clk),
            .rst_n(resetn),
            .push(push[g]),
            .din(wr[g]),
            .pop(pop[g]),
            .head(head[g]),
            .full(full[g]),
            .empty(empty[g]),
            .single(single[g])
        );
    end

    always_comb begin
        hit = '0;
        hit_any = 1'b0;
        sel_data = '0;
        sel_joined = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!hit_any && !empty[i] && head[i].sn == next_sn) begin
                hit[i] = 1'b1;
                hit_any = 1'b1;
                sel_data = head[i].data;
                sel_joined = head[i].joined;
            end
        end
    end

    assign out_fire = out_valid && bus.out_ready;
    assign out_free = !out_valid || bus.out_ready;
    assign pop_ok = (state == RUN || state == DRAIN) && hit_any
                    && (!sel_joined || out_free);
    assign pop = pop_ok ? hit : '0;
    assign load_rec = pop_ok && sel_joined;
    assign drain_eff = state == DRAIN || (state == RUN && all_last);
    assign all_empty = &empty;

    // The pop is final when every lane is left empty with nothing arriving
    always_comb begin
        empty_after = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (push[i] || !(empty[i] || (pop[i] && single[i])))
                empty_after = 1'b0;
        end
    end

    assign final_pop = drain_eff && empty_after;
    assign term_go = all_empty && !(|push) && !out_last;
    assign load_term = state == TERM && out_free
                       && !(out_valid && out_last);

    always_comb begin
        state_nx = state;
        unique case (state)
            RUN: if (all_last) state_nx = DRAIN;
            DRAIN: begin
                if (out_fire && out_last) state_nx = DONE;
                else if (term_go) state_nx = TERM;
            end
            TERM: if (out_fire && out_last) state_nx = DONE;
            DONE: state_nx = DONE;
        endcase
    end

    always_comb begin
        ord_bad = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            logic [SN_W-1:0] d_last;
            logic [SN_W-1:0] d_next;
            d_last = wr[i].sn - last_sn[i];
            d_next = wr[i].sn - next_sn;
            if (push[i]) begin
                if (seen[i])
                    ord_bad |= (d_last == '0) || half_ge(64'(d_last), SN_W);
                else
                    ord_bad |= half_ge(64'(d_next), SN_W);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= RUN;
            ready_en <= 1'b0;
        end else begin
            state <= state_nx;
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_last <= 1'b0;
            out_empty <= 1'b0;
            out_data <= '0;
        end else if (load_rec) begin
            out_valid <= 1'b1;
            out_last <= final_pop;
            out_empty <= 1'b0;
            out_data <= sel_data;
        end else if (load_term) begin
            out_valid <= 1'b1;
            out_last <= 1'b1;
            out_empty <= 1'b1;
            out_data <= '0;
        end else if (out_fire) begin
            out_valid <= 1'b0;
            out_last <= 1'b0;
            out_empty <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            next_sn <= '0;
            joined_cnt <= '0;
            dropped_cnt <= '0;
            order_err <= 1'b0;
        end else begin
            if (pop_ok) next_sn <= next_sn + SN_W'(1);
            if (load_rec) joined_cnt <= joined_cnt + 32'd1;
            if (pop_ok && !sel_joined) dropped_cnt <= dropped_cnt + 32'd1;
            order_err <= order_err | ord_bad;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seen <= '0;
            for (int i = 0; i < NUM_LANES; i++) last_sn[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (push[i]) begin
                    seen[i] <= 1'b1;
                    last_sn[i] <= wr[i].sn;
                end
            end
        end
    end

    assign bus.in_ready = rdy;
    assign bus.out_data = out_data;
    assign bus.out_valid = out_valid;
    assign bus.out_last = out_last;
    assign bus.out_empty = out_empty;
    assign bus.next_sn = next_sn;
    assign bus.order_err = order_err;
    assign bus.joined_cnt = joined_cnt;
    assign bus.dropped_cnt = dropped_cnt;
endmodule
